// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: decodes the ALU subset into SrcA/SrcB/alu_ctrl and
// holds the result in a one-entry ID/EX register with valid/ready and flush.
module alu_issue_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] pc,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] src_a,
  output logic [WIDTH-1:0] src_b,
  output logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] store_data,
  output logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] pc_out,
  output logic [4:0]       rd_addr,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             branch,
  output logic             branch_ne,
  output logic             illegal
);
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                         ALU_OR  = 3'b011, ALU_XOR = 3'b100;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I  = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011;

  typedef struct packed {
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] store_data;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] pc;
    logic [4:0]       rd;
    logic [2:0]       alu;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             branch;
    logic             branch_ne;
    logic             illegal;
  } dec_t;

  dec_t dec_d, dec_q;
  logic vld_d, vld_q;
  logic ok, load;

  logic [6:0]       opcode, f7;
  logic [2:0]       f3;
  logic             f3_logic;
  logic [WIDTH-1:0] imm_i, imm_s, imm_b;

  assign opcode   = instr[6:0];
  assign f3       = instr[14:12];
  assign f7       = instr[31:25];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign f3_logic = (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) || (f3 == 3'b100);

  assign imm_i = {{(WIDTH-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{(WIDTH-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  function automatic logic [2:0] alu_of(input logic [2:0] fn3);
    case (fn3)
      3'b111:  return ALU_AND;
      3'b110:  return ALU_OR;
      3'b100:  return ALU_XOR;
      default: return ALU_ADD;
    endcase
  endfunction

  always_comb begin
    ok                 = 1'b0;
    dec_d              = '0;
    dec_d.src_a        = rs1_data;
    dec_d.src_b        = rs2_data;
    dec_d.store_data   = rs2_data;
    dec_d.pc           = pc;
    case (opcode)
      OP_R: begin
        dec_d.rd        = instr[11:7];
        dec_d.reg_write = 1'b1;
        if (f7 == 7'b0100000 && f3 == 3'b000) begin
          dec_d.alu = ALU_SUB;
          ok        = 1'b1;
        end else if (f7 == 7'b0000000 && f3_logic) begin
          dec_d.alu = alu_of(f3);
          ok        = 1'b1;
        end
      end
      OP_I: begin
        ok              = f3_logic;
        dec_d.alu       = alu_of(f3);
        dec_d.imm       = imm_i;
        dec_d.src_b     = imm_i;
        dec_d.rd        = instr[11:7];
        dec_d.reg_write = 1'b1;
      end
      OP_LD: begin
        ok              = (f3 == 3'b010);
        dec_d.imm       = imm_i;
        dec_d.src_b     = imm_i;
        dec_d.rd        = instr[11:7];
        dec_d.reg_write = 1'b1;
        dec_d.mem_read  = 1'b1;
      end
      OP_ST: begin
        ok              = (f3 == 3'b010);
        dec_d.imm       = imm_s;
        dec_d.src_b     = imm_s;
        dec_d.mem_write = 1'b1;
      end
      OP_BR: begin
        ok              = (f3[2:1] == 2'b00);
        dec_d.alu       = ALU_SUB;
        dec_d.imm       = imm_b;
        dec_d.branch    = 1'b1;
        dec_d.branch_ne = f3[0];
      end
      default: ok = 1'b0;
    endcase
    // x0 is never a real destination
    if (dec_d.rd == 5'd0) dec_d.reg_write = 1'b0;
    if (!ok) begin
      dec_d.alu       = ALU_ADD;
      dec_d.imm       = '0;
      dec_d.rd        = '0;
      dec_d.reg_write = 1'b0;
      dec_d.mem_read  = 1'b0;
      dec_d.mem_write = 1'b0;
      dec_d.branch    = 1'b0;
      dec_d.branch_ne = 1'b0;
      dec_d.illegal   = 1'b1;
    end
  end

  assign in_ready = ~vld_q | out_ready;
  // flush wins over a same-cycle accept: the word is dropped, not stored
  assign load     = in_valid & in_ready & ~flush;

  always_comb begin
    vld_d = vld_q;
    if (flush)                  vld_d = 1'b0;
    else if (load)              vld_d = 1'b1;
    else if (vld_q & out_ready) vld_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      dec_q <= '0;
    end else begin
      vld_q <= vld_d;
      if (load) dec_q <= dec_d;
    end
  end

  assign out_valid  = vld_q;
  assign src_a      = dec_q.src_a;
  assign src_b      = dec_q.src_b;
  assign alu_ctrl   = dec_q.alu;
  assign store_data = dec_q.store_data;
  assign imm        = dec_q.imm;
  assign pc_out     = dec_q.pc;
  assign rd_addr    = dec_q.rd;
  assign reg_write  = dec_q.reg_write;
  assign mem_read   = dec_q.mem_read;
  assign mem_write  = dec_q.mem_write;
  assign branch     = dec_q.branch;
  assign branch_ne  = dec_q.branch_ne;
  assign illegal    = dec_q.illegal;
endmodule
